rs5_plic: RTL and testbench

Platform-level interrupt controller for the RS5 SoC, mapped on the data bus at 0x3000_0000–0x7FFF_FFFF (the top-level decoder asserts `en_i`). It gathers up to `i_cnt` level-triggered peripheral interrupt lines and arbitrates them by priority against a threshold. It raises a single machine external interrupt (`irq_o`, MEIP) to the core. It implements a claim/complete handshake for a single hart context.

---
 rtl/plic_pkg.sv | 32 +++
 rtl/plic_gateway.sv | 49 ++++
 rtl/rs5_plic.sv | 156 +++++++++++++++
 tb/tb_rs5_plic.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// Shared register-map constants and decode types for the RS5 platform-level
// interrupt controller.
package plic_pkg;

   localparam int unsigned PRIO_W = 3;

   localparam logic [23:0] PRIO_BASE = 24'h000000;
   localparam logic [23:0] PEND_OFS  = 24'h001000;
   localparam logic [23:0] EN_OFS    = 24'h002000;
   localparam logic [23:0] THR_OFS   = 24'h200000;
   localparam logic [23:0] CLAIM_OFS = 24'h200004;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_PRIO,
      SEL_PEND,
      SEL_EN,
      SEL_THR,
      SEL_CLAIM
   } reg_sel_e;

   // Bits 1..n set; bit 0 and bits above n stay clear.
   function automatic logic [31:0] src_mask(input int unsigned n);
      logic [31:0] m;
      m = '0;
      for (int unsigned i = 1; i <= n; i++) begin
         if (i < 32) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: latches a level request as pending, masks it while the
// source is claimed but not yet completed, and issues the completion ack.
module plic_gateway (
   input  logic clk_i,
   input  logic rst_i,
   input  logic irq_i,
   input  logic claim_i,
   input  logic complete_i,
   output logic pending_o,
   output logic iack_o
);

   logic pend_q, pend_d;
   logic infl_q, infl_d;
   logic iack_q, iack_d;

   always_comb begin
      pend_d = pend_q;
      infl_d = infl_q;
      iack_d = 1'b0;
      // A claim overrides a coincident request rise for this source.
      if (claim_i) begin
         pend_d = 1'b0;
         infl_d = 1'b1;
      end else begin
         if (irq_i && !pend_q && !infl_q) pend_d = 1'b1;
         if (complete_i && infl_q) begin
            infl_d = 1'b0;
            iack_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q <= 1'b0;
         infl_q <= 1'b0;
         iack_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         infl_q <= infl_d;
         iack_q <= iack_d;
      end
   end

   assign pending_o = pend_q;
   assign iack_o    = iack_q;

endmodule

// File: rtl/rs5_plic.sv
// RS5 platform-level interrupt controller: register file, priority arbiter,
// claim/complete handshake and machine external interrupt for one hart.
module rs5_plic
   import plic_pkg::*;
#(
   parameter int unsigned i_cnt = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic [3:0]       we_i,
   input  logic [23:0]      addr_i,
   input  logic [31:0]      data_i,
   output logic [31:0]      data_o,
   input  logic [i_cnt:1]   irq_i,
   input  logic             iack_i,
   output logic [i_cnt:1]   iack_o,
   output logic             irq_o
);

   localparam logic [31:0] SRC_MASK = src_mask(i_cnt);

   logic [PRIO_W-1:0] prio_q [1:i_cnt];
   logic [PRIO_W-1:0] prio_d [1:i_cnt];
   logic [31:0]       en_q, en_d;
   logic [PRIO_W-1:0] thr_q, thr_d;
   logic              taken_q, taken_d;
   logic [31:0]       data_q, data_d;
   logic              irq_q, irq_d;

   logic [i_cnt:1]    pend, claim_src, cmpl_src;
   logic [31:0]       pend_word;
   reg_sel_e          sel;
   logic [9:0]        widx;
   logic              wr, rd, claim_hit;
   logic [4:0]        win_id;
   logic [PRIO_W-1:0] win_prio;
   logic              unused_addr;

   assign wr          = en_i && (we_i != '0);
   assign rd          = en_i && (we_i == '0);
   assign widx        = addr_i[11:2];
   assign unused_addr = ^addr_i[1:0];

   always_comb begin
      sel = SEL_NONE;
      if (addr_i[23:2] == PEND_OFS[23:2])       sel = SEL_PEND;
      else if (addr_i[23:2] == EN_OFS[23:2])    sel = SEL_EN;
      else if (addr_i[23:2] == THR_OFS[23:2])   sel = SEL_THR;
      else if (addr_i[23:2] == CLAIM_OFS[23:2]) sel = SEL_CLAIM;
      else if (addr_i[23:12] == PRIO_BASE[23:12] && widx != '0 && widx <= 10'(i_cnt))
         sel = SEL_PRIO;
   end

   // Strict compare seeded with the threshold: ties keep the lowest id.
   always_comb begin
      win_id   = '0;
      win_prio = thr_q;
      for (int unsigned i = 1; i <= i_cnt; i++) begin
         if (pend[i] && en_q[i] && prio_q[i] > win_prio) begin
            win_id   = 5'(i);
            win_prio = prio_q[i];
         end
      end
   end

   assign claim_hit = rd && (sel == SEL_CLAIM) && (win_id != '0);

   always_comb begin
      pend_word = '0;
      claim_src = '0;
      cmpl_src  = '0;
      for (int unsigned i = 1; i <= i_cnt; i++) begin
         pend_word[i] = pend[i];
         claim_src[i] = claim_hit && (win_id == 5'(i));
         cmpl_src[i]  = wr && (sel == SEL_CLAIM) && we_i[0] && (data_i[4:0] == 5'(i));
      end
   end

   always_comb begin
      prio_d = prio_q;
      en_d   = en_q;
      thr_d  = thr_q;
      data_d = data_q;
      if (wr) begin
         case (sel)
            SEL_PRIO: begin
               for (int unsigned i = 1; i <= i_cnt; i++) begin
                  if (we_i[0] && widx == 10'(i)) prio_d[i] = data_i[PRIO_W-1:0];
               end
            end
            SEL_EN: begin
               for (int unsigned b = 0; b < 4; b++) begin
                  if (we_i[b]) en_d[8*b +: 8] = data_i[8*b +: 8];
               end
               en_d = en_d & SRC_MASK;
            end
            SEL_THR: if (we_i[0]) thr_d = data_i[PRIO_W-1:0];
            default: ;
         endcase
      end
      if (rd) begin
         case (sel)
            SEL_PRIO: begin
               data_d = '0;
               for (int unsigned i = 1; i <= i_cnt; i++) begin
                  if (widx == 10'(i)) data_d = 32'(prio_q[i]);
               end
            end
            SEL_PEND:  data_d = pend_word;
            SEL_EN:    data_d = en_q;
            SEL_THR:   data_d = 32'(thr_q);
            SEL_CLAIM: data_d = 32'(win_id);
            default:   data_d = '0;
         endcase
      end
   end

   // A successful claim re-arms the trap even if the core acks in the same cycle.
   assign taken_d = claim_hit ? 1'b0 : (iack_i ? 1'b1 : taken_q);
   assign irq_d   = (win_id != '0) && !taken_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 1; i <= i_cnt; i++) prio_q[i] <= '0;
         en_q    <= '0;
         thr_q   <= '0;
         taken_q <= 1'b0;
         data_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         prio_q  <= prio_d;
         en_q    <= en_d;
         thr_q   <= thr_d;
         taken_q <= taken_d;
         data_q  <= data_d;
         irq_q   <= irq_d;
      end
   end

   for (genvar g = 1; g <= i_cnt; g++) begin : g_src
      plic_gateway u_gw (
         .clk_i      (clk),
         .rst_i      (reset),
         .irq_i      (irq_i[g]),
         .claim_i    (claim_src[g]),
         .complete_i (cmpl_src[g]),
         .pending_o  (pend[g]),
         .iack_o     (iack_o[g])
      );
   end

   assign data_o = data_q;
   assign irq_o  = irq_q;

endmodule

// File: tb/tb_rs5_plic.sv
// Directed bench for rs5_plic with a cycle-level reference model of the
// register map, gateways and claim/complete flow.
module tb_rs5_plic;

   localparam int unsigned N = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          en = 1'b0;
   logic [3:0]    we = '0;
   logic [23:0]   addr = '0;
   logic [31:0]   wdata = '0;
   logic [31:0]   rdata;
   logic [N:1]    irq = '0;
   logic          iack_in = 1'b0;
   logic [N:1]    iack_out;
   logic          irq_out;

   always #5 clk = ~clk;

   rs5_plic #(.i_cnt(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .en_i   (en),
      .we_i   (we),
      .addr_i (addr),
      .data_i (wdata),
      .data_o (rdata),
      .irq_i  (irq),
      .iack_i (iack_in),
      .iack_o (iack_out),
      .irq_o  (irq_out)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_prio [1:N] = '{default: 0};
   logic [31:0] m_en = '0;
   int          m_thr = 0;
   bit          m_pend [1:N] = '{default: 1'b0};
   bit          m_infl [1:N] = '{default: 1'b0};
   bit          m_taken = 1'b0;
   logic [31:0] exp_data = '0;
   logic        exp_irq = 1'b0;
   logic [N:1]  exp_iack = '0;
   bit          checking = 1'b0;

   function automatic int winner();
      for (int p = 7; p > m_thr; p--)
         for (int id = 1; id <= N; id++)
            if (m_pend[id] && m_en[id] && m_prio[id] == p) return id;
      return 0;
   endfunction

   function automatic logic [31:0] read_model(input logic [31:0] a, input int w);
      logic [31:0] v;
      v = '0;
      case (a)
         32'h0000_1000: for (int id = 1; id <= N; id++) v[id] = m_pend[id];
         32'h0000_2000: v = m_en;
         32'h0020_0000: v = m_thr;
         32'h0020_0004: v = w;
         default: if (a >= 4 && a <= 4 * N) v = m_prio[a / 4];
      endcase
      return v;
   endfunction

   function automatic void write_model(input logic [31:0] a);
      int id;
      logic [31:0] mask;
      mask = ((32'd1 << (N + 1)) - 32'd1) & ~32'd1;
      case (a)
         32'h0000_2000: begin
            for (int b = 0; b < 4; b++) if (we[b]) m_en[8*b +: 8] = wdata[8*b +: 8];
            m_en = m_en & mask;
         end
         32'h0020_0000: if (we[0]) m_thr = wdata[2:0];
         32'h0020_0004: if (we[0]) begin
            id = wdata[4:0];
            if (id >= 1 && id <= N && m_infl[id]) begin
               m_infl[id]   = 1'b0;
               exp_iack[id] = 1'b1;
            end
         end
         default: if (a >= 4 && a <= 4 * N && we[0]) m_prio[a / 4] = wdata[2:0];
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin : model
      int w;
      logic [31:0] a;
      bit opend [1:N];
      bit oinfl [1:N];
      if (reset) begin
         m_prio = '{default: 0};
         m_en = '0; m_thr = 0; m_taken = 1'b0;
         m_pend = '{default: 1'b0};
         m_infl = '{default: 1'b0};
         exp_data = '0; exp_irq = 1'b0; exp_iack = '0;
      end else begin
         w = winner();
         exp_irq  = (w != 0) && !m_taken;
         exp_iack = '0;
         opend = m_pend;
         oinfl = m_infl;
         a = {8'h00, addr[23:2], 2'b00};
         if (en && we == 4'h0) exp_data = read_model(a, w);
         if (en && we != 4'h0) write_model(a);
         if (en && we == 4'h0 && a == 32'h0020_0004 && w != 0) begin
            m_pend[w] = 1'b0;
            m_infl[w] = 1'b1;
            m_taken   = 1'b0;
         end else if (iack_in) begin
            m_taken = 1'b1;
         end
         for (int id = 1; id <= N; id++)
            if (!(en && we == 4'h0 && a == 32'h0020_0004 && w == id))
               if (irq[id] && !opend[id] && !oinfl[id]) m_pend[id] = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("data_o", rdata, exp_data);
         chk("irq_o", 32'(irq_out), 32'(exp_irq));
         chk("iack_o", 32'(iack_out), 32'(exp_iack));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bwr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
      en = 1'b1; we = be; addr = a; wdata = d;
      step();
      en = 1'b0; we = '0;
   endtask

   task automatic brd(input logic [23:0] a, input string name, input logic [31:0] exp);
      en = 1'b1; we = '0; addr = a;
      step();
      en = 1'b0;
      chk(name, rdata, exp);
   endtask

   initial begin
      step(2);
      reset = 1'b0;
      checking = 1'b1;

      brd(24'h001000, "rst_pend", 32'h0);
      brd(24'h200004, "rst_claim", 32'h0);
      chk("rst_irq", 32'(irq_out), 32'h0);
      chk("rst_iack", 32'(iack_out), 32'h0);

      // basic claim / complete on source 1
      bwr(24'h000004, 32'd1);
      bwr(24'h002000, 32'h2);
      irq = 3'b001;
      step(1);
      brd(24'h001000, "pend_set", 32'h2);
      chk("irq_basic", 32'(irq_out), 32'h1);
      brd(24'h200004, "claim1", 32'd1);
      step(1);
      chk("irq_after_claim", 32'(irq_out), 32'h0);
      brd(24'h001000, "inflight_mask", 32'h0);
      step(3);
      brd(24'h001000, "inflight_mask2", 32'h0);
      bwr(24'h200004, 32'd1);
      chk("iack_pulse", 32'(iack_out), 32'h1);
      step(1);
      chk("iack_one_cycle", 32'(iack_out), 32'h0);
      brd(24'h001000, "repend", 32'h2);
      bwr(24'h200004, 32'd2);
      chk("no_iack_unclaimed2", 32'(iack_out), 32'h0);
      bwr(24'h200004, 32'd1);
      chk("no_iack_pending_only", 32'(iack_out), 32'h0);
      irq = '0;
      brd(24'h200004, "claim1b", 32'd1);
      bwr(24'h200004, 32'd1);
      step(1);

      // enable masking, byte lanes, unmapped space
      bwr(24'h002000, 32'hFFFF_FFFF);
      brd(24'h002000, "en_mask", 32'h0000_000E);
      bwr(24'h002000, 32'hFFFF_FF00, 4'b0001);
      brd(24'h002000, "en_bytelane", 32'h0);
      bwr(24'h002000, 32'h0000_0002, 4'b1110);
      brd(24'h002000, "en_lane0_off", 32'h0);
      bwr(24'h002000, 32'h2);
      brd(24'h000010, "prio_oob", 32'h0);
      bwr(24'h000010, 32'd7);
      brd(24'h000010, "prio_oob_wr", 32'h0);
      brd(24'h000004, "prio1", 32'd1);
      bwr(24'h003000, 32'd5);
      brd(24'h003000, "unmapped", 32'h0);

      // threshold gating
      bwr(24'h000004, 32'd2);
      bwr(24'h200000, 32'd2);
      irq = 3'b001;
      step(2);
      chk("thr_block", 32'(irq_out), 32'h0);
      bwr(24'h200000, 32'd1);
      step(1);
      chk("thr_open", 32'(irq_out), 32'h1);
      brd(24'h200000, "thr_rd", 32'd1);

      // taken flag
      iack_in = 1'b1;
      step(1);
      iack_in = 1'b0;
      step(1);
      chk("irq_taken", 32'(irq_out), 32'h0);
      brd(24'h200004, "claim_after_iack", 32'd1);
      step(1);
      chk("irq_none_eligible", 32'(irq_out), 32'h0);
      bwr(24'h200004, 32'd1);
      step(2);
      chk("irq_reeligible", 32'(irq_out), 32'h1);
      bwr(24'h000008, 32'd3);
      bwr(24'h002000, 32'h6);
      irq = 3'b011;
      step(2);
      iack_in = 1'b1;
      brd(24'h200004, "claim_with_iack", 32'd2);
      iack_in = 1'b0;
      step(1);
      chk("taken_cleared_by_claim", 32'(irq_out), 32'h1);
      irq = '0;
      brd(24'h200004, "claim_rest", 32'd1);
      bwr(24'h200004, 32'd2);
      bwr(24'h200004, 32'd1);
      step(2);

      // arbitration
      bwr(24'h000004, 32'd3);
      bwr(24'h000008, 32'd5);
      bwr(24'h00000C, 32'd5);
      bwr(24'h002000, 32'hE);
      bwr(24'h200000, 32'd0);
      irq = 3'b111;
      step(2);
      brd(24'h200004, "arb_a", 32'd2);
      brd(24'h200004, "arb_b", 32'd3);
      brd(24'h200004, "arb_c", 32'd1);
      brd(24'h200004, "arb_d", 32'd0);
      step(1);
      chk("arb_irq_idle", 32'(irq_out), 32'h0);
      irq = '0;
      bwr(24'h200004, 32'd3);
      chk("arb_iack3", 32'(iack_out), 32'h4);
      bwr(24'h200004, 32'd2);
      chk("arb_iack2", 32'(iack_out), 32'h2);
      bwr(24'h200004, 32'd1);
      chk("arb_iack1", 32'(iack_out), 32'h1);

      // pending word is read-only
      irq = 3'b100;
      step(1);
      bwr(24'h001000, 32'h0);
      brd(24'h001000, "pend_ro", 32'h8);
      brd(24'h200004, "claim3", 32'd3);
      irq = '0;
      bwr(24'h200004, 32'd3);

      // reset in the middle of a claimed transaction
      irq = 3'b001;
      step(2);
      brd(24'h200004, "pre_reset_claim", 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_async_data", rdata, 32'h0);
      step(2);
      reset = 1'b0;
      brd(24'h002000, "rst_en", 32'h0);
      brd(24'h000004, "rst_prio", 32'h0);
      bwr(24'h000004, 32'd1);
      bwr(24'h002000, 32'h2);
      step(1);
      brd(24'h001000, "post_reset_pend", 32'h2);
      brd(24'h200004, "post_reset_claim", 32'd1);
      step(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
